// File: rtl/div_stall_ctrl.sv
// -----------------------------------------------------------------------------
// div_stall_ctrl
//
// Pipeline stall controller for the 5-stage core. It also sequences the shared
// multi-cycle restoring divider used by the EX stage.
//
// Stall requests from ID (load-use and similar) and from the divider are merged
// into one per-stage stall vector. The vector is ordered
// bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
//
// The divider performs one quotient bit per clock, MSB first, over DATA_W
// steps. Signed operands are reduced to magnitudes when the operation is
// accepted, and the signs are reapplied when the result is loaded. The result
// is packed {remainder, quotient} so that EX can write HI/LO directly.
//
// Ports
//   clk            core clock, rising edge
//   rst            asynchronous, active-high reset
//   stallreq_id_i  stall request from ID
//   start_i        EX requests a divide; held high until ready_o is seen
//   annul_i        abort the current divide (EX instruction squashed)
//   signed_div_i   1 = DIV (signed), 0 = DIVU; sampled at acceptance
//   opdata1_i      dividend; sampled at acceptance
//   opdata2_i      divisor; sampled at acceptance
//   result_o       {remainder, quotient}
//   ready_o        result valid (registered)
//   stall_o        per-stage stall vector (combinational)
// -----------------------------------------------------------------------------
module div_stall_ctrl #(
    parameter int DATA_W  = 32,
    parameter int STALL_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallreq_id_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic [STALL_W-1:0]    stall_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [DATA_W-1:0]  DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]  DATA_ZERO = '0;
    // EX stall holds pc/if/id/ex; an ID stall holds pc/if/id only.
    localparam logic [STALL_W-1:0] STALL_EX  = {{(STALL_W-4){1'b0}}, 4'b1111};
    localparam logic [STALL_W-1:0] STALL_ID  = {{(STALL_W-3){1'b0}}, 3'b111};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dvd_sh;   // dividend magnitude, shifted out MSB first
    logic [DATA_W-1:0] dvs;      // divisor magnitude
    logic [DATA_W-1:0] rem;      // partial remainder
    logic [DATA_W-1:0] quo;      // quotient bits collected so far
    logic              q_neg;
    logic              r_neg;

    logic              accept;
    logic              div_busy;
    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] diff;
    logic              q_bit;
    logic [DATA_W-1:0] rem_step;
    logic              diff_unused;

    // Magnitude of a value, treating it as two's complement only when asked.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                              input logic               is_signed);
        logic signed [DATA_W-1:0] sv;
        sv = v;
        return (is_signed && sv < 0) ? (~v + DATA_ONE) : v;
    endfunction

    // Conditional two's-complement negate used to reapply the result signs.
    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                                 input logic               neg);
        return neg ? (~v + DATA_ONE) : v;
    endfunction

    assign accept = start_i & ~annul_i;

    // One restoring step. The shifted partial remainder is 33 bits wide, and
    // the extra top bit of diff is the borrow. Because rem < dvs always holds,
    // a successful subtraction leaves a value that fits in DATA_W bits, so
    // diff[DATA_W] carries no information.
    assign shifted     = {rem, dvd_sh[DATA_W-1]};
    assign diff        = {1'b0, shifted} - {2'b00, dvs};
    assign q_bit       = ~diff[DATA_W+1];
    assign rem_step    = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign diff_unused = diff[DATA_W];

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (opdata2_i == DATA_ZERO) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                state_nxt = annul_i ? S_IDLE : S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_END;
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control state, counter and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    ready_o <= 1'b0;
                    if (accept && opdata2_i != DATA_ZERO) begin
                        cnt <= '0;
                    end
                end
                S_BYZERO: begin
                    if (!annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (!annul_i) begin
                        if (cnt == CNT_LAST) begin
                            result_o <= {neg_if(rem, r_neg), neg_if(quo, q_neg)};
                            ready_o  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        ready_o <= 1'b0;
                    end
                end
                default: ready_o <= 1'b0;
            endcase
        end
    end

    // Divider datapath. It is loaded at acceptance, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && accept) begin
            dvd_sh <= mag(opdata1_i, signed_div_i);
            dvs    <= mag(opdata2_i, signed_div_i);
            rem    <= '0;
            quo    <= '0;
            q_neg  <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            r_neg  <= signed_div_i & opdata1_i[DATA_W-1];
        end else if (state == S_ON && !annul_i && cnt != CNT_LAST) begin
            rem    <= rem_step;
            quo    <= {quo[DATA_W-2:0], q_bit};
            dvd_sh <= {dvd_sh[DATA_W-2:0], 1'b0};
        end
    end

    // Stall merge. The divider request is a superset of the ID request, so it
    // takes priority. Reset forces the vector low even while start_i is held.
    assign div_busy = start_i & ~ready_o & ~annul_i;

    always_comb begin
        stall_o = '0;
        if (!rst) begin
            if (div_busy) begin
                stall_o = STALL_EX;
            end else if (stallreq_id_i) begin
                stall_o = STALL_ID;
            end
        end
    end

endmodule

// File: tb/tb_div_stall_ctrl.sv
module tb_div_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id_i;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic [5:0]  stall_o;

    int checks = 0;
    int errors = 0;

    div_stall_ctrl #(.DATA_W(32), .STALL_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id_i (stallreq_id_i),
        .start_i       (start_i),
        .annul_i       (annul_i),
        .signed_div_i  (signed_div_i),
        .opdata1_i     (opdata1_i),
        .opdata2_i     (opdata2_i),
        .result_o      (result_o),
        .ready_o       (ready_o),
        .stall_o       (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The caller is at a negedge. The next posedge is the acceptance edge
    // (edge 1). Operands are scrambled after acceptance to show that they are
    // not resampled.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp, input int exp_edges);
        int edges;
        start_i      = 1'b1;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        edges        = 0;
        while (!ready_o && edges < 40) begin
            @(negedge clk);
            edges++;
            if (edges == 1) begin
                chk({tag, "_stall_busy"}, stall_o, 6'b001111);
                opdata1_i    = ~a;
                opdata2_i    = b + 32'd3;
                signed_div_i = ~sgn;
            end
        end
        chk({tag, "_latency"}, edges, exp_edges);
        chk({tag, "_ready"}, ready_o, 1'b1);
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_stall_done"}, stall_o, 6'b000000);
        @(negedge clk);
        chk({tag, "_hold_ready"}, ready_o, 1'b1);
        chk({tag, "_hold_result"}, result_o, exp);
        start_i = 1'b0;
        @(negedge clk);
        chk({tag, "_drop_ready"}, ready_o, 1'b0);
        chk({tag, "_drop_stall"}, stall_o, 6'b000000);
        chk({tag, "_keep_result"}, result_o, exp);
    endtask

    initial begin
        rst           = 1'b1;
        stallreq_id_i = 1'b0;
        start_i       = 1'b0;
        annul_i       = 1'b0;
        signed_div_i  = 1'b0;
        opdata1_i     = '0;
        opdata2_i     = '0;
        #1;
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_result", result_o, 64'h0);
        chk("rst_stall", stall_o, 6'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned and signed divides
        do_div("udiv_100_7",  32'd100,        32'd7,          1'b0, {32'd2, 32'd14}, 34);
        do_div("sdiv_m7_2",   32'hFFFFFFF9,   32'd2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
        do_div("sdiv_ovf",    32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h0, 32'h80000000}, 34);
        do_div("sdiv_7_m2",   32'd7,          32'hFFFFFFFE,   1'b1, {32'd1, 32'hFFFFFFFD}, 34);
        do_div("udiv_big",    32'hFFFFFFF9,   32'd2,          1'b0, {32'd1, 32'h7FFFFFFC}, 34);

        // Divide by zero
        do_div("sdiv_zero",   32'hFFFFFFF9,   32'd0,          1'b1, 64'h0, 2);
        do_div("udiv_100_7b", 32'd100,        32'd7,          1'b0, {32'd2, 32'd14}, 34);
        do_div("udiv_zero",   32'd12345,      32'd0,          1'b0, 64'h0, 2);

        // Stall arbitration. No clock edge passes while start and annul
        // overlap, so nothing is accepted.
        stallreq_id_i = 1'b1;
        #1;
        chk("arb_id_only", stall_o, 6'b000111);
        start_i = 1'b1;
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        #1;
        chk("arb_both", stall_o, 6'b001111);
        annul_i = 1'b1;
        #1;
        chk("arb_annul_id", stall_o, 6'b000111);
        start_i = 1'b0;
        annul_i = 1'b0;
        stallreq_id_i = 1'b0;
        #1;
        chk("arb_none", stall_o, 6'b000000);
        @(negedge clk);

        // Annul on edge 10, then restart on edge 12
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd5000;
        opdata2_i    = 32'd3;
        for (int e = 1; e <= 9; e++) @(negedge clk);
        chk("annul_pre_ready", ready_o, 1'b0);
        annul_i = 1'b1;
        #1;
        chk("annul_stall_drop", stall_o, 6'b000000);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        chk("annul_e10_ready", ready_o, 1'b0);
        @(negedge clk);
        chk("annul_e11_ready", ready_o, 1'b0);
        chk("annul_e11_result", result_o, 64'h0);
        do_div("annul_restart", 32'd1000, 32'd10, 1'b0, {32'd0, 32'd100}, 34);

        // Asynchronous reset while ON, with counter at 17 after edge 18
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd77777;
        opdata2_i    = 32'd13;
        for (int e = 1; e <= 18; e++) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_ready", ready_o, 1'b0);
        chk("arst_result", result_o, 64'h0);
        chk("arst_stall", stall_o, 6'b000000);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_post_ready", ready_o, 1'b0);
        do_div("arst_udiv", 32'hFFFFFFFF, 32'h10, 1'b0, {32'hF, 32'h0FFFFFFF}, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
